// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive frame FIFO.
package eth_pkg;

   localparam int ETH_MIN_FRAME = 64;
   localparam int ETH_MAX_FRAME = 1518;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RECV    = 2'd1,
      ST_DISCARD = 2'd2
   } wr_state_t;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/eth_rx_frame_fifo_if.sv
// Byte-stream ingress, consumer egress and status of the receive frame FIFO.
interface eth_rx_frame_fifo_if
   import eth_pkg::*;
#(
   parameter int DEPTH = 2048,
   parameter int CNT_W = 16
);
   localparam int PTR_W = ptr_w(DEPTH);

   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_sof;
   logic             in_eof;
   logic             in_err;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_sof;
   logic             out_eof;
   logic [PTR_W-1:0] frames_avail;
   logic             drop_pulse;
   logic [CNT_W-1:0] drop_count;

   modport master (
      output in_data, in_valid, in_sof, in_eof, in_err, out_ready,
      input  out_data, out_valid, out_sof, out_eof, frames_avail, drop_pulse, drop_count
   );

   modport slave (
      input  in_data, in_valid, in_sof, in_eof, in_err, out_ready,
      output out_data, out_valid, out_sof, out_eof, frames_avail, drop_pulse, drop_count
   );
endinterface

// File: rtl/eth_rx_frame_fifo_ram.sv
// Simple dual-port storage with a registered, enable-gated read port.
module eth_rx_frame_fifo_ram #(
   parameter int DEPTH = 2048,
   parameter int WIDTH = 9,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   // write port
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // read register doubles as the consumer-facing output register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward receive frame FIFO: bytes are written speculatively and only
// whole frames that end cleanly within length limits become readable.
module eth_rx_frame_fifo
   import eth_pkg::*;
#(
   parameter int DEPTH   = 2048,
   parameter int MIN_LEN = ETH_MIN_FRAME,
   parameter int MAX_LEN = ETH_MAX_FRAME,
   parameter int CNT_W   = 16
) (
   input logic                clk,
   input logic                rst_n,
   eth_rx_frame_fifo_if.slave bus
);
   localparam int PTR_W = ptr_w(DEPTH);
   localparam int AW    = PTR_W - 1;
   localparam int LEN_W = $clog2(MAX_LEN + 2);
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] MIN_P   = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] MAX_P   = LEN_W'(MAX_LEN);
   localparam logic SINGLE_BAD = (MIN_LEN > 1) || (MAX_LEN < 1);

   wr_state_t        r_state, w_state_nxt;
   logic [PTR_W-1:0] r_wr_commit, w_wr_commit_nxt, r_wr_cur, w_wr_cur_nxt, r_rd;
   logic [LEN_W-1:0] r_len, w_len_nxt, w_len_inc;
   logic             r_err_seen, w_err_nxt;
   logic             w_we, w_commit, w_drop, w_start, w_bad_end, w_full_cur, w_full_start;
   logic [PTR_W-1:0] w_waddr;
   logic             r_out_valid, r_out_sof, r_at_sof, w_load, w_hs;
   logic [8:0]       w_rdata;
   logic [PTR_W-1:0] r_frames_avail;
   logic             r_drop_pulse;
   logic [CNT_W-1:0] r_drop_count;

   assign w_full_cur   = (r_wr_cur - r_rd) == DEPTH_P;
   assign w_full_start = (r_wr_commit - r_rd) == DEPTH_P;
   assign w_len_inc    = (r_len == LEN_SAT) ? r_len : r_len + LEN_W'(1);
   assign w_bad_end    = r_err_seen | bus.in_err | (w_len_inc < MIN_P) | (w_len_inc > MAX_P);

   // write FSM next state; a frame start is shared by IDLE, restart and DISCARD
   always_comb begin
      w_state_nxt     = r_state;
      w_wr_commit_nxt = r_wr_commit;
      w_wr_cur_nxt    = r_wr_cur;
      w_len_nxt       = r_len;
      w_err_nxt       = r_err_seen;
      w_we            = 1'b0;
      w_waddr         = r_wr_cur;
      w_commit        = 1'b0;
      w_drop          = 1'b0;
      w_start         = 1'b0;
      case (r_state)
         ST_RECV: begin
            if (!bus.in_valid) begin
               w_start = 1'b0;
            end else if (bus.in_eof) begin
               w_wr_cur_nxt = r_wr_commit;
               w_state_nxt  = ST_IDLE;
               if (w_full_cur || w_bad_end) begin
                  w_drop = 1'b1;
               end else begin
                  w_we            = 1'b1;
                  w_commit        = 1'b1;
                  w_wr_commit_nxt = r_wr_cur + PTR_W'(1);
                  w_wr_cur_nxt    = r_wr_cur + PTR_W'(1);
               end
            end else if (bus.in_sof) begin
               w_drop  = 1'b1;
               w_start = 1'b1;
            end else if (w_full_cur) begin
               w_state_nxt = ST_DISCARD;
            end else begin
               w_we         = 1'b1;
               w_wr_cur_nxt = r_wr_cur + PTR_W'(1);
               w_len_nxt    = w_len_inc;
               w_err_nxt    = r_err_seen | bus.in_err;
            end
         end
         ST_DISCARD: begin
            if (bus.in_valid && bus.in_eof) begin
               w_drop       = 1'b1;
               w_wr_cur_nxt = r_wr_commit;
               w_state_nxt  = ST_IDLE;
            end else if (bus.in_valid && bus.in_sof) begin
               w_drop  = 1'b1;
               w_start = 1'b1;
            end else begin
               w_start = 1'b0;
            end
         end
         default: begin
            w_start = bus.in_valid & bus.in_sof;
         end
      endcase
      if (w_start) begin
         w_waddr   = r_wr_commit;
         w_len_nxt = LEN_W'(1);
         w_err_nxt = bus.in_err;
         if (w_full_start) begin
            w_wr_cur_nxt = r_wr_commit;
            w_drop       = w_drop | bus.in_eof;
            w_state_nxt  = bus.in_eof ? ST_IDLE : ST_DISCARD;
         end else if (bus.in_eof && (bus.in_err || SINGLE_BAD)) begin
            w_drop       = 1'b1;
            w_wr_cur_nxt = r_wr_commit;
            w_state_nxt  = ST_IDLE;
         end else if (bus.in_eof) begin
            w_we            = 1'b1;
            w_commit        = 1'b1;
            w_wr_commit_nxt = r_wr_commit + PTR_W'(1);
            w_wr_cur_nxt    = r_wr_commit + PTR_W'(1);
            w_state_nxt     = ST_IDLE;
         end else begin
            w_we         = 1'b1;
            w_wr_cur_nxt = r_wr_commit + PTR_W'(1);
            w_state_nxt  = ST_RECV;
         end
      end else begin
         w_waddr = w_waddr;
      end
   end

   // write FSM state and pointer registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_wr_commit <= '0;
         r_wr_cur    <= '0;
         r_len       <= '0;
         r_err_seen  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_wr_commit <= w_wr_commit_nxt;
         r_wr_cur    <= w_wr_cur_nxt;
         r_len       <= w_len_nxt;
         r_err_seen  <= w_err_nxt;
      end
   end

   assign w_hs   = r_out_valid & bus.out_ready;
   assign w_load = (~r_out_valid | bus.out_ready) & (r_rd != r_wr_commit);

   eth_rx_frame_fifo_ram #(.DEPTH(DEPTH), .WIDTH(9), .AW(AW)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_we),
      .i_waddr (w_waddr[AW-1:0]),
      .i_wdata ({bus.in_eof, bus.in_data}),
      .i_re    (w_load),
      .i_raddr (r_rd[AW-1:0]),
      .o_rdata (w_rdata)
   );

   // read pointer and output flags; a byte is a frame start if the byte
   // handshaken just before it carried eof
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd        <= '0;
         r_out_valid <= 1'b0;
         r_out_sof   <= 1'b0;
         r_at_sof    <= 1'b1;
      end else begin
         if (w_load) begin
            r_rd        <= r_rd + PTR_W'(1);
            r_out_valid <= 1'b1;
            r_out_sof   <= r_out_valid ? w_rdata[8] : r_at_sof;
         end else if (w_hs) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
         end
         if (w_hs) begin
            r_at_sof <= w_rdata[8];
         end
      end
   end

   // frame bookkeeping and drop statistics
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frames_avail <= '0;
         r_drop_pulse   <= 1'b0;
         r_drop_count   <= '0;
      end else begin
         case ({w_commit, w_hs & w_rdata[8]})
            2'b10:   r_frames_avail <= r_frames_avail + PTR_W'(1);
            2'b01:   r_frames_avail <= r_frames_avail - PTR_W'(1);
            default: r_frames_avail <= r_frames_avail;
         endcase
         r_drop_pulse <= w_drop;
         if (w_drop && !(&r_drop_count)) begin
            r_drop_count <= r_drop_count + CNT_W'(1);
         end
      end
   end

   assign bus.out_valid    = r_out_valid;
   assign bus.out_sof      = r_out_sof;
   assign bus.out_eof      = w_rdata[8];
   assign bus.out_data     = w_rdata[7:0];
   assign bus.frames_avail = r_frames_avail;
   assign bus.drop_pulse   = r_drop_pulse;
   assign bus.drop_count   = r_drop_count;
endmodule
